// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. Each transaction is granted in IDLE, held on the memory in
// ACCESS until mem_ready or timeout, and answered by a one-cycle response
// pulse in RESP.
// Optional feature macro: MEM_ARB_FAIR_EN. When defined, a fetch that has
// been waiting through MAX_STREAK data grants wins the next arbitration.
// Without it, data always wins.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // The counter runs 0 .. TIMEOUT-1 while waiting in ACCESS.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             owner_d_q;   // 1: data port owns the transaction
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic fetch_turn;
    logic pick_if;
    logic pick_d;
    logic timed_out;

`ifdef MEM_ARB_FAIR_EN
    localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;

    // Count data grants that made a waiting fetch wait; saturate at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (pick_if || !if_req) begin
                streak_q <= '0;
            end else if (pick_d && (streak_q != STREAK_MAX)) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end
    end

    assign fetch_turn = (streak_q == STREAK_MAX);
`else
    // Strict data priority: any legal MAX_STREAK (>= 1) never hands fetch the turn.
    assign fetch_turn = (MAX_STREAK < 1);
`endif

    // Arbitrate only in IDLE: data first unless the fetch has been starved
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            pick_if = if_req && (!d_req || fetch_turn);
            pick_d  = d_req && !pick_if;
        end
    end

    assign timed_out = (cnt_q == CNT_LAST);

    // Next-state logic; mem_ready wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pick_if || pick_d)      state_d = ST_ACCESS;
            ST_ACCESS: if (mem_ready || timed_out) state_d = ST_RESP;
            ST_RESP:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards any transaction in flight
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction registers: request capture at grant, result capture in ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_if || pick_d) begin
                        owner_d_q <= pick_d;
                        we_q      <= pick_d && d_we;
                        addr_q    <= pick_d ? d_addr : if_addr;
                        wdata_q   <= pick_d ? d_wdata : '0;
                        cnt_q     <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Grants are combinational from IDLE and forced low while reset is held
    assign if_gnt    = pick_if && !rst;
    assign d_gnt     = pick_d && !rst;

    assign if_rvalid = (state_q == ST_RESP) && !owner_d_q;
    assign d_rvalid  = (state_q == ST_RESP) && owner_d_q;
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign d_rdata   = d_rvalid ? rdata_q : '0;
    assign err       = (state_q == ST_RESP) && err_q;

    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Requesters and the memory are
// modelled at transaction level: the bench decides the winner from the
// priority rule, owns a word memory, and predicts response data, err and
// the exact cycle of every grant, memory access and response pulse.
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 16;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .TIMEOUT    (TIMEOUT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending requests as the requesters see them (held until granted)
    logic        pend_if = 1'b0;
    logic [31:0] pif_addr = '0;
    logic        pend_d = 1'b0;
    logic        pd_we = 1'b0;
    logic [31:0] pd_addr = '0;
    logic [31:0] pd_wdata = '0;

    // Bench memory and the fairness streak of the reference model
    logic [31:0] mem_model [logic [31:0]];
    int          streak = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Reference priority rule
    function automatic bit model_pick_if();
`ifdef MEM_ARB_FAIR_EN
        return pend_if && (!pend_d || streak >= MAX_STREAK);
`else
        return pend_if && !pend_d;
`endif
    endfunction

    // Streak bookkeeping for one IDLE cycle (uses if_req as presented that cycle)
    task automatic model_idle_cycle(input bit g_if, input bit g_d);
        if (g_if || !pend_if) streak = 0;
        else if (g_d && streak < MAX_STREAK) streak++;
    endtask

    task automatic new_if(input logic [31:0] a);
        pend_if  = 1'b1;
        pif_addr = a;
    endtask

    task automatic new_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        pend_d   = 1'b1;
        pd_we    = we;
        pd_addr  = a;
        pd_wdata = wd;
    endtask

    task automatic drive();
        if_req  = pend_if;
        if_addr = pif_addr;
        d_req   = pend_d;
        d_we    = pd_we;
        d_addr  = pd_addr;
        d_wdata = pd_wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_if_gnt"}, if_gnt, 1'b0);
        check1({tag, "_d_gnt"}, d_gnt, 1'b0);
        check1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        check1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        check1({tag, "_mem_req"}, mem_req, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        check32({tag, "_mem_addr"}, mem_addr, 32'h0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check32({tag, "_if_rdata"}, if_rdata, 32'h0);
        check32({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    // Idle cycles with no requests; stray mem_ready must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            check_all_zero("idle");
            model_idle_cycle(1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    // One complete transaction from IDLE. delay = ACCESS cycles before
    // mem_ready (>= TIMEOUT means never). raise_*_at: ACCESS cycle index at
    // which a new request appears (negative = none).
    task automatic serve(input int delay, input int raise_if_at, input int raise_d_at);
        bit          win_if;
        bit          done;
        logic        we_e;
        logic [31:0] a_e;
        logic [31:0] wd_e;
        logic [31:0] rd_e;
        logic        err_e;

        // IDLE: grant
        drive();
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        win_if = model_pick_if();
        check1("if_gnt", if_gnt, win_if);
        check1("d_gnt", d_gnt, !win_if && pend_d);
        check1("mem_req_at_gnt", mem_req, 1'b0);
        we_e = win_if ? 1'b0 : pd_we;
        a_e  = win_if ? pif_addr : pd_addr;
        wd_e = pd_wdata;
        model_idle_cycle(win_if, !win_if);
        if (win_if) pend_if = 1'b0;
        else        pend_d  = 1'b0;
        @(posedge clk);
        #1;

        // ACCESS: bounded by the timeout
        done  = 1'b0;
        rd_e  = '0;
        err_e = 1'b1;
        for (int i = 0; i < TIMEOUT && !done; i++) begin
            if (i == raise_if_at && !pend_if) new_if(32'($urandom_range(0, 15)) << 2);
            if (i == raise_d_at && !pend_d)
                new_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
            drive();
            mem_ready = (i == delay);
            mem_rdata = (mem_ready && !we_e) ? mem_val(a_e) : $urandom;
            #1;
            check1("mem_req", mem_req, 1'b1);
            check1("mem_we", mem_we, we_e);
            check32("mem_addr", mem_addr, a_e);
            if (we_e) check32("mem_wdata", mem_wdata, wd_e);
            check1("busy_if_gnt", if_gnt, 1'b0);
            check1("busy_d_gnt", d_gnt, 1'b0);
            check1("busy_rvalid", if_rvalid | d_rvalid, 1'b0);
            if (i == delay) begin
                done  = 1'b1;
                err_e = 1'b0;
                rd_e  = we_e ? 32'h0 : mem_val(a_e);
                if (we_e) mem_model[a_e] = wd_e;
            end
            @(posedge clk);
            #1;
        end

        // RESP: one pulse to the owner
        drive();
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check1("if_rvalid", if_rvalid, win_if);
        check1("d_rvalid", d_rvalid, !win_if);
        check1("err", err, err_e);
        if (win_if) check32("if_rdata", if_rdata, rd_e);
        else        check32("d_rdata", d_rdata, rd_e);
        check1("resp_mem_req", mem_req, 1'b0);
        check1("resp_gnt", if_gnt | d_gnt, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        new_if(32'h4);
        new_d(1'b1, 32'h8, 32'hFFFF_FFFF);
        drive();
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        pend_if = 1'b0;
        pend_d  = 1'b0;
        drive();
        rst = 1'b0;
        #1;
        idle(2);

        // Single load, one-cycle memory
        mem_model[32'h40] = 32'hDEAD_BEEF;
        new_d(1'b0, 32'h40, 32'h0);
        serve(0, -1, -1);

        // Store acknowledged on the third ACCESS cycle, then read back
        new_d(1'b1, 32'h10, 32'h1234_5678);
        serve(2, -1, -1);
        new_d(1'b0, 32'h10, 32'h0);
        serve(1, -1, -1);

        // Contention: fetch waits behind a stream of data requests
        new_if(32'h100);
        for (int k = 0; k < 6; k++) begin
            if (!pend_d) new_d(1'b0, 32'(k) << 2, 32'h0);
            serve(0, -1, -1);
        end
        for (int k = 0; k < 2; k++) begin
            if (pend_if || pend_d) serve(0, -1, -1);
        end

        // Timeout on a fetch, then success on the last allowed cycle
        new_if(32'h200);
        serve(TIMEOUT + 5, -1, -1);
        new_d(1'b0, 32'h204, 32'h0);
        serve(TIMEOUT - 1, -1, -1);
        idle(3);

        // Fetch request arriving while a data load is in ACCESS
        new_d(1'b0, 32'h300, 32'h0);
        serve(2, 1, -1);
        serve(0, -1, -1);

        // Reset two cycles into ACCESS
        new_d(1'b0, 32'h80, 32'h0);
        drive();
        mem_ready = 1'b0;
        #1;
        check1("rst_t_d_gnt", d_gnt, !model_pick_if());
        model_idle_cycle(1'b0, 1'b1);
        pend_d = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            drive();
            #1;
            check1("rst_t_access", mem_req, 1'b1);
            @(posedge clk);
            #1;
        end
        new_if(32'h44);
        new_d(1'b0, 32'h48, 32'h0);
        drive();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        check_all_zero("midrst_held");
        pend_if = 1'b0;
        pend_d  = 1'b0;
        drive();
        rst    = 1'b0;
        streak = 0;
        #1;
        idle(3);
        new_d(1'b0, 32'h80, 32'h0);
        serve(1, -1, -1);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int r;
            int delay;
            if (!pend_if && !pend_d) begin
                r = int'($urandom_range(0, 2));
                if (r != 1) new_if(32'($urandom_range(0, 15)) << 2);
                if (r != 0) new_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
            end
            r = int'($urandom_range(0, 9));
            if (r < 7)       delay = r % 4;
            else if (r == 7) delay = TIMEOUT - 1;
            else             delay = TIMEOUT + r;
            serve(delay, int'($urandom_range(0, 6)) - 2, int'($urandom_range(0, 6)) - 2);
            if ($urandom_range(0, 4) == 0 && !pend_if && !pend_d) idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
